// File: rtl/toy_arb_pkg.sv
// Shared definitions for the toy memory arbiter: state encoding,
// memory direction codes and default bus widths.
package toy_arb_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 8;

  // Memory direction as seen on the RORW pins.
  localparam logic RORW_READ  = 1'b1;
  localparam logic RORW_WRITE = 1'b0;

  // Access sequencer states; one access walks IDLE -> ISSUE -> WAIT -> COMPLETE.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT     = 2'd2,
    ST_COMPLETE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/toy_rr_pick.sv
// Two-way winner select for the toy memory arbiter.
// Default build: round-robin pointer, handed to the losing port on every grant.
// With TOY_ARB_FIXED_PRIO_EN defined: port 0 always wins, no pointer exists.
module toy_rr_pick (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic grant,
  output logic winner
);

`ifdef TOY_ARB_FIXED_PRIO_EN
  logic unused_pick;
  assign unused_pick = clk ^ rst_n ^ grant ^ req1;

  // Port 0 wins whenever it asks; otherwise port 1 gets the slot.
  always_comb begin
    winner = ~req0;
  end
`else
  logic ptr_q;
  logic ptr_d;

  // Lone requester wins outright; a tie goes to whichever port the pointer favours.
  always_comb begin
    winner = (req0 && req1) ? ptr_q : req1;
  end

  // After each grant the pointer favours the port that just lost.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = ~winner;
  end

  // Pointer register; reset favours port 0.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/toy_mem_arbiter.sv
// Toy machine memory arbiter: shares one synchronous memory port between
// the CPU (port 0) and the loader/debug requester (port 1). Each access is
// sequenced IDLE -> ISSUE -> WAIT(MEM_LAT) -> COMPLETE and ends with a DONE pulse.
// Optional build macro: TOY_ARB_FIXED_PRIO_EN (port 0 always wins ties).
module toy_mem_arbiter
  import toy_arb_pkg::*;
#(
  parameter int AW      = AW_DEFAULT,
  parameter int DW      = DW_DEFAULT,
  parameter int MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          RORW0,
  input  logic          RORW1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic          GNT0,
  output logic          GNT1,
  output logic          DONE0,
  output logic          DONE1,
  output logic [DW-1:0] RDATA0,
  output logic [DW-1:0] RDATA1,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] D_OUT,
  input  logic [DW-1:0] D_IN,
  output logic          MEM_EN,
  output logic          RORW,
  output logic          S0,
  output logic          S1,
  output logic          S2,
  output logic          S3
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(MEM_LAT - 1);

  arb_state_e    state_q, state_d;
  logic          winner_q, winner_d;
  logic          rorw_q, rorw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          pick_winner;
  logic          arb_go;

  // Arbitration only happens while idle; requests during an access simply wait.
  assign arb_go = (state_q == ST_IDLE) && (REQ0 || REQ1);

  toy_rr_pick u_pick (
    .clk    (CLK),
    .rst_n  (RESET),
    .req0   (REQ0),
    .req1   (REQ1),
    .grant  (arb_go),
    .winner (pick_winner)
  );

  // State register; reset abandons any access in flight.
  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: fixed walk through one access, WAIT length set by the down-counter.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (arb_go) state_d = ST_ISSUE;
      ST_ISSUE:    state_d = ST_WAIT;
      ST_WAIT:     if (cnt_q == '0) state_d = ST_COMPLETE;
      ST_COMPLETE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and per-port read-data capture.
  always_comb begin
    winner_d = winner_q;
    rorw_d   = rorw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (arb_go) begin
      winner_d = pick_winner;
      rorw_d   = pick_winner ? RORW1  : RORW0;
      addr_d   = pick_winner ? ADDR1  : ADDR0;
      wdata_d  = pick_winner ? WDATA1 : WDATA0;
    end
    if (state_q == ST_ISSUE) begin
      cnt_d = WAIT_LOAD;
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
    if ((state_q == ST_WAIT) && (cnt_q == '0) && (rorw_q != RORW_WRITE)) begin
      if (winner_q) rdata1_d = D_IN;
      else          rdata0_d = D_IN;
    end
  end

  // Datapath registers; memory pins idle at read/address 0 out of reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      winner_q <= 1'b0;
      rorw_q   <= RORW_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      winner_q <= winner_d;
      rorw_q   <= rorw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Control outputs decoded purely from registered state.
  always_comb begin
    MEM_EN = (state_q == ST_ISSUE);
    GNT0   = (state_q != ST_IDLE) && !winner_q;
    GNT1   = (state_q != ST_IDLE) &&  winner_q;
    DONE0  = (state_q == ST_COMPLETE) && !winner_q;
    DONE1  = (state_q == ST_COMPLETE) &&  winner_q;
    S0     = (state_q == ST_IDLE);
    S1     = (state_q == ST_ISSUE);
    S2     = (state_q == ST_WAIT);
    S3     = (state_q == ST_COMPLETE);
  end

  assign ADDR   = addr_q;
  assign RORW   = rorw_q;
  assign D_OUT  = wdata_q;
  assign RDATA0 = rdata0_q;
  assign RDATA1 = rdata1_q;

endmodule

// File: doc/toy_mem_arbiter.md
Name: toy_mem_arbiter

Overview:
- Shares the toy machine's single synchronous memory port (ADDR, D_OUT, D_IN, MEM_EN, RORW) between two requesters.
  - Port 0: the toy CPU core.
  - Port 1: the program loader / debug requester.
- Sequences each access through a fixed ISSUE / WAIT / COMPLETE state machine.
- Returns read data with a one-cycle DONE pulse.
- Exposes one-hot state bits for bench visibility.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MEM_LAT, 1, cycles from the MEM_EN cycle to valid D_IN (≥1).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-low reset.
- REQ0, REQ1  in  1 each  access request from port 0 / port 1.
- RORW0, RORW1  in  1 each  1 = read, 0 = write.
- ADDR0, ADDR1  in  AW each  request address.
- WDATA0, WDATA1  in  DW each  write data.
- GNT0, GNT1  out  1 each  port owns the memory for the current access.
- DONE0, DONE1  out  1 each  one-cycle completion pulse.
- RDATA0, RDATA1  out  DW each  last read data returned to that port.
- ADDR  out  AW  memory address.
- D_OUT  out  DW  memory write data.
- D_IN  in  DW  memory read data.
- MEM_EN  out  1  memory enable.
- RORW  out  1  memory direction, 1 = read.
- S0..S3  out  1 each  one-hot state: IDLE, ISSUE, WAIT, COMPLETE.

Behaviour:
- Reset (RESET=0 at a rising edge, mid-operation included):
  - State returns to IDLE.
  - MEM_EN=0, RORW=1, ADDR=0, D_OUT=0.
  - GNTx=0, DONEx=0, RDATAx=0.
  - Round-robin pointer favours port 0.
  - S0=1, S1..S3=0.
  - Any in-flight access is abandoned; no DONE is issued for it.
- All outputs are registered or decoded from registered state; no combinational path from REQ to memory pins.
- Handshake:
  - A requester raises REQx with RORWx/ADDRx/WDATAx stable and holds them until DONEx.
  - REQx may be dropped before GNTx rises (withdraw); the arbiter ignores it.
  - After DONEx, the requester must drop REQx for at least one cycle or present a new request; a held REQx is treated as a new request.
- State machine:
  - IDLE: if any REQ is high at the edge, select a winner, latch its RORW/ADDR/WDATA, go to ISSUE.
  - ISSUE (1 cycle): MEM_EN=1; ADDR, RORW, D_OUT driven from the latched request; GNTwinner=1. For a write, memory commits at the ending edge. Go to WAIT.
  - WAIT (MEM_LAT cycles, down-counter): MEM_EN=0, address/direction held, GNT held. On the last WAIT edge, a read captures D_IN into RDATAwinner; a write leaves RDATA unchanged. Go to COMPLETE.
  - COMPLETE (1 cycle): DONEwinner=1, GNT held. Go to IDLE.
- Latency:
  - REQ sampled at edge E0.
  - MEM_EN high E0–E1.
  - DONE high E(1+MEM_LAT)–E(2+MEM_LAT).
  - Next arbitration at E(2+MEM_LAT).
  - Access period is 3+MEM_LAT cycles.
- Arbitration:
  - Only one REQ high → that port wins.
  - Both high → the pointer-favoured port wins.
  - On each grant the pointer flips to favour the other port.
  - Arbitration happens only in IDLE; requests arriving during an access wait.
- RDATAx holds its value until the next completed read for that port.
- Exactly one of S0..S3 is high at all times.
- MEM_EN is never high outside ISSUE.

Optional Feature:
- Macro TOY_ARB_FIXED_PRIO_EN.
  - Defined: port 0 (CPU) always wins simultaneous requests; the pointer is not implemented.
  - Undefined: round-robin as above.
- Timing and handshake are identical in both builds.

Decomposition:
- Package toy_arb_pkg:
  - State encoding constants ST_IDLE, ST_ISSUE, ST_WAIT, ST_COMPLETE.
  - RORW_READ=1, RORW_WRITE=0.
  - Default AW/DW.
- Sub-module toy_rr_pick:
  - 2-way winner select plus pointer register.
  - Takes REQ0/REQ1 and a grant strobe; yields the winner index.
  - Under TOY_ARB_FIXED_PRIO_EN it reduces to fixed priority.

Test Plan (200 ns clock, stimulus changed 35 ns after edge, MEM_LAT=1):
- Reset held low for 2 edges mid-access (during WAIT) → next cycle S0=1, MEM_EN=0, GNT/DONE=0, RDATA=0, no DONE pulse follows.
- Port 0 read, ADDR0=8'h01, memory model returns 8'hAA → MEM_EN for exactly 1 cycle with ADDR=8'h01, RORW=1; DONE0 pulses 2 cycles after the MEM_EN cycle; RDATA0=8'hAA.
- Port 1 write, ADDR1=8'h04, WDATA1=8'hFE → ISSUE cycle shows RORW=0, D_OUT=8'hFE; memory holds 8'hFE at 8'h04; DONE1 pulses; RDATA1 unchanged.
- REQ0 and REQ1 both held continuously, round-robin build → grants alternate 0,1,0,1; each access is 4 cycles apart. Fixed-prio build → port 0 granted every access, port 1 starved.
- REQ1 raised then dropped within the access of port 0 → no GNT1, no DONE1, no memory cycle for port 1.
- Port 0 read 8'h10→8'hFF, then port 0 write to 8'h08 → RDATA0 stays 8'hFF after the write completes.
